mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store) of the 5-stage pipeline.
- Serialises requests, registers the memory-side command, and returns data with a one-cycle ready pulse.
- Drives a global pipeline stall while either requester waits.
- Data requests have fixed priority, bounded by a starvation counter that guarantees fetch progress.

Parameters:
ADDR_W, 32, address width of requesters and memory port
DATA_W, 32, data width
STARVE_MAX, 4, number of consecutive data grants made while a fetch is pending before the next fetch is forced (1..15)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
if_req_i  in  1  fetch request, held until if_ready_o
if_addr_i  in  ADDR_W  fetch address, stable while if_req_i high
if_rdata_o  out  DATA_W  fetched instruction, valid when if_ready_o
if_ready_o  out  1  one-cycle completion pulse for fetch
d_req_i  in  1  data request, held until d_ready_o
d_we_i  in  1  1 = store, 0 = load
d_addr_i  in  ADDR_W  data address
d_wdata_i  in  DATA_W  store data
d_rdata_o  out  DATA_W  load data, valid when d_ready_o
d_ready_o  out  1  one-cycle completion pulse for data
mem_req_o  out  1  memory command valid, held until mem_ack_i
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_rdata_i  in  DATA_W  memory read data, valid with mem_ack_i
mem_ack_i  in  1  memory completion, one cycle
stall_o  out  1  pipeline stall
busy_o  out  1  transaction in flight (state is not IDLE)

Behaviour:
- States: IDLE, BUSY_IF, BUSY_D, DONE_IF, DONE_D.
- Reset: state IDLE; starvation counter 0; all outputs 0, including registered rdata. Reset is asynchronous and takes effect mid-transaction: the in-flight access is abandoned and no ready pulse is issued.
- IDLE arbitration, on the clock edge:
  - d_req_i only -> BUSY_D.
  - if_req_i only -> BUSY_IF.
  - Both requesting -> BUSY_D, unless starve_cnt == STARVE_MAX, in which case -> BUSY_IF.
  - Neither requesting -> stay in IDLE.
- Grant latch: on any grant, the winner's addr/we/wdata are latched into mem_addr_o/mem_we_o/mem_wdata_o. A fetch forces mem_we_o = 0 and mem_wdata_o = 0.
- BUSY_x: mem_req_o = 1 and the command is held constant. On mem_ack_i = 1 -> DONE_x.
  - DONE_IF: mem_rdata_i is registered into if_rdata_o.
  - DONE_D, load: mem_rdata_i is registered into d_rdata_o.
  - DONE_D, store: d_rdata_o is unchanged.
  - mem_req_o drops in the DONE state.
- DONE_x: x_ready_o = 1 for exactly this cycle, then unconditionally -> IDLE. A requester that still holds req in IDLE has made a new request.
- Ignored inputs: mem_ack_i is ignored in IDLE and DONE; request inputs are ignored outside IDLE.
- Latency: request seen in IDLE at cycle 0 -> mem_req_o high at cycle 1 -> ack at cycle k>=1 -> ready at cycle k+1. Minimum is 2 cycles to ready; the IDLE bubble gives 3 cycles between back-to-back grants.
- Starvation counter (saturating, 4-bit):
  - Increments on each data grant made while if_req_i = 1.
  - Clears on each fetch grant.
  - Holds when a data grant is made with if_req_i = 0.
- stall_o = (if_req_i & ~if_ready_o) | (d_req_i & ~d_ready_o). This is combinational from registered ready and the inputs. It is 0 in the cycle of the requester's ready pulse.
- if_rdata_o and d_rdata_o retain their values between transactions.
- Protocol violation (request dropped before ready): the transaction still completes and the ready pulse is still issued; the bench does not check data in this case.

Test Plan:
- Fetch only, memory ack delay 0:
  - Stimulus: if_req_i = 1, if_addr_i = 0x00000010, mem_ack_i high in cycle 1 with mem_rdata_i = 0x00A00093.
  - Required: mem_req_o = 1, mem_addr_o = 0x10, mem_we_o = 0 in cycle 1; if_ready_o = 1 and if_rdata_o = 0x00A00093 in cycle 2; stall_o = 1 in cycles 0–1 and 0 in cycle 2.
- Store with 3-cycle memory latency:
  - Stimulus: d_req_i = 1, d_we_i = 1, d_addr_i = 0x40, d_wdata_i = 0xDEADBEEF.
  - Required: mem_req_o held 3 cycles with we = 1, addr = 0x40, wdata = 0xDEADBEEF; d_ready_o pulses once; d_rdata_o unchanged from its prior value.
- Simultaneous requests, both held, STARVE_MAX = 4:
  - Required: grant order D, D, D, D, IF, D, ...; starve_cnt reads 4 before the IF grant and 0 after.
- Reset mid-transaction:
  - Stimulus: rst_i driven low in a BUSY_D cycle; mem_ack_i pulses after release.
  - Required: all outputs 0 immediately; no d_ready_o pulse; late ack ignored; state IDLE.
- Load, then immediate fetch:
  - Stimulus: load from 0x80 returns 0x12345678; if_req_i rises in the DONE_D cycle.
  - Required: d_rdata_o = 0x12345678 with d_ready_o; fetch granted from the following IDLE cycle; if_rdata_o retains its previous value until its own DONE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported, variable-latency memory between the instruction
// fetch stage (read-only) and the load/store stage of the pipeline.
// Requests are serialised through a small FSM; the memory command is
// registered at grant time and held until the memory acknowledges.
// Read data is registered and returned with a one-cycle ready pulse.
// Data requests win by default. A starvation counter forces a fetch grant
// after STARVE_MAX consecutive data grants made while a fetch was waiting.
//
// Ports
//   clk_i, rst_i             clock (rising edge), async active-low reset
//   if_req_i/if_addr_i       fetch request and address
//   if_rdata_o/if_ready_o    fetched word and its completion pulse
//   d_req_i/d_we_i/d_addr_i  data request, store flag, and address
//   d_wdata_i                store data
//   d_rdata_o/d_ready_o      load data and its completion pulse
//   mem_req_o/mem_we_o       memory command valid and write enable
//   mem_addr_o/mem_wdata_o   memory command address and write data
//   mem_rdata_i/mem_ack_i    memory read data and one-cycle completion
//   stall_o                  pipeline stall while any requester waits
//   busy_o                   a transaction is in flight
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ready_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ready_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_o,
  output logic              busy_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BUSY_IF = 3'd1,
    BUSY_D  = 3'd2,
    DONE_IF = 3'd3,
    DONE_D  = 3'd4
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state_r;
  state_t     state_s;
  logic [3:0] starve_cnt_r;
  logic       starve_hit_s;
  logic       grant_if_s;
  logic       grant_d_s;

  assign starve_hit_s = (starve_cnt_r == STARVE_LIM);

  // Next-state and grant decode; requests only matter in IDLE, ack only in BUSY.
  always_comb begin
    state_s    = state_r;
    grant_if_s = 1'b0;
    grant_d_s  = 1'b0;
    case (state_r)
      IDLE: begin
        // Data wins unless a waiting fetch has been passed over STARVE_MAX times.
        if (d_req_i && !(if_req_i && starve_hit_s)) begin
          grant_d_s = 1'b1;
          state_s   = BUSY_D;
        end else if (if_req_i) begin
          grant_if_s = 1'b1;
          state_s    = BUSY_IF;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY_IF: begin
        if (mem_ack_i) begin
          state_s = DONE_IF;
        end else begin
          state_s = BUSY_IF;
        end
      end
      BUSY_D: begin
        if (mem_ack_i) begin
          state_s = DONE_D;
        end else begin
          state_s = BUSY_D;
        end
      end
      DONE_IF: state_s = IDLE;
      DONE_D:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Starvation counter: counts data grants that bypass a waiting fetch.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      starve_cnt_r <= 4'd0;
    end else if (grant_if_s) begin
      starve_cnt_r <= 4'd0;
    end else if (grant_d_s && if_req_i && (starve_cnt_r != 4'hF)) begin
      starve_cnt_r <= starve_cnt_r + 4'd1;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // Memory command latch; a fetch never writes, so its we/wdata are zeroed.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else if (grant_d_s) begin
      mem_we_o    <= d_we_i;
      mem_addr_o  <= d_addr_i;
      mem_wdata_o <= d_wdata_i;
    end else if (grant_if_s) begin
      mem_we_o    <= 1'b0;
      mem_addr_o  <= if_addr_i;
      mem_wdata_o <= '0;
    end else begin
      mem_we_o    <= mem_we_o;
      mem_addr_o  <= mem_addr_o;
      mem_wdata_o <= mem_wdata_o;
    end
  end

  // Registered status/handshake outputs, decoded from the next state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_req_o  <= 1'b0;
      if_ready_o <= 1'b0;
      d_ready_o  <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      mem_req_o  <= (state_s == BUSY_IF) || (state_s == BUSY_D);
      if_ready_o <= (state_s == DONE_IF);
      d_ready_o  <= (state_s == DONE_D);
      busy_o     <= (state_s != IDLE);
    end
  end

  // Read-data capture; values persist between transactions, stores leave d_rdata alone.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      if_rdata_o <= '0;
      d_rdata_o  <= '0;
    end else begin
      if ((state_r == BUSY_IF) && mem_ack_i) begin
        if_rdata_o <= mem_rdata_i;
      end else begin
        if_rdata_o <= if_rdata_o;
      end
      if ((state_r == BUSY_D) && mem_ack_i && !mem_we_o) begin
        d_rdata_o <= mem_rdata_i;
      end else begin
        d_rdata_o <= d_rdata_o;
      end
    end
  end

  // Stall while any requester is still waiting for its ready pulse.
  assign stall_o = (if_req_i & ~if_ready_o) | (d_req_i & ~d_ready_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ready_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [31:0] d_rdata_o;
  logic        d_ready_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        stall_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ready_o(if_ready_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_rdata_o(d_rdata_o), .d_ready_o(d_ready_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .stall_o(stall_o), .busy_o(busy_o)
  );

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        e_mem_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_if_ready;
    logic [31:0] e_if_rdata;
    logic        e_d_ready;
    logic [31:0] e_d_rdata;
    logic        e_stall;
    logic        e_busy;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  localparam logic [31:0] I = 32'h00A00093;
  localparam logic [31:0] L = 32'h12345678;
  localparam logic [31:0] J = 32'h00000013;
  localparam logic [31:0] B = 32'hDEADBEEF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    if_req_i = 1'b0; if_addr_i = 32'h0; d_req_i = 1'b0; d_we_i = 1'b0;
    d_addr_i = 32'h0; d_wdata_i = 32'h0; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
  endtask

  logic [31:0] exp_addr [6];
  logic [3:0]  exp_cnt  [6];
  int          ngrant;
  logic        prev_req;
  bit          seen_busy;

  initial begin
    // Fetch 0x10, load 0x80 with fetch raised in DONE_D, store 0x40 (3-cycle latency), idle ack.
    //          if  ifaddr    d  we daddr     dwdata ack rdata          | mreq we addr     wdata ifr ifrdata dr drdata st bz
    vecs[0]  = '{0, 32'h0,    0, 0, 32'h0,  32'h0, 0, 32'h0,           0, 0, 32'h0,  32'h0, 0, 32'h0, 0, 32'h0, 0, 0};
    vecs[1]  = '{1, 32'h10,   0, 0, 32'h0,  32'h0, 0, 32'h0,           0, 0, 32'h0,  32'h0, 0, 32'h0, 0, 32'h0, 1, 0};
    vecs[2]  = '{1, 32'h10,   0, 0, 32'h0,  32'h0, 1, I,               1, 0, 32'h10, 32'h0, 0, 32'h0, 0, 32'h0, 1, 1};
    vecs[3]  = '{1, 32'h10,   0, 0, 32'h0,  32'h0, 0, 32'h0,           0, 0, 32'h10, 32'h0, 1, I,     0, 32'h0, 0, 1};
    vecs[4]  = '{0, 32'h0,    0, 0, 32'h0,  32'h0, 0, 32'h0,           0, 0, 32'h10, 32'h0, 0, I,     0, 32'h0, 0, 0};
    vecs[5]  = '{0, 32'h0,    1, 0, 32'h80, 32'h0, 0, 32'h0,           0, 0, 32'h10, 32'h0, 0, I,     0, 32'h0, 1, 0};
    vecs[6]  = '{0, 32'h0,    1, 0, 32'h80, 32'h0, 0, 32'h0,           1, 0, 32'h80, 32'h0, 0, I,     0, 32'h0, 1, 1};
    vecs[7]  = '{0, 32'h0,    1, 0, 32'h80, 32'h0, 1, L,               1, 0, 32'h80, 32'h0, 0, I,     0, 32'h0, 1, 1};
    vecs[8]  = '{1, 32'h14,   1, 0, 32'h80, 32'h0, 0, 32'h0,           0, 0, 32'h80, 32'h0, 0, I,     1, L,     1, 1};
    vecs[9]  = '{1, 32'h14,   0, 0, 32'h0,  32'h0, 0, 32'h0,           0, 0, 32'h80, 32'h0, 0, I,     0, L,     1, 0};
    vecs[10] = '{1, 32'h14,   0, 0, 32'h0,  32'h0, 0, 32'h0,           1, 0, 32'h14, 32'h0, 0, I,     0, L,     1, 1};
    vecs[11] = '{1, 32'h14,   0, 0, 32'h0,  32'h0, 1, J,               1, 0, 32'h14, 32'h0, 0, I,     0, L,     1, 1};
    vecs[12] = '{1, 32'h14,   0, 0, 32'h0,  32'h0, 0, 32'h0,           0, 0, 32'h14, 32'h0, 1, J,     0, L,     0, 1};
    vecs[13] = '{0, 32'h0,    0, 0, 32'h0,  32'h0, 0, 32'h0,           0, 0, 32'h14, 32'h0, 0, J,     0, L,     0, 0};
    vecs[14] = '{0, 32'h0,    1, 1, 32'h40, B,     0, 32'h0,           0, 0, 32'h14, 32'h0, 0, J,     0, L,     1, 0};
    vecs[15] = '{0, 32'h0,    1, 1, 32'h40, B,     0, 32'h0,           1, 1, 32'h40, B,     0, J,     0, L,     1, 1};
    vecs[16] = '{0, 32'h0,    1, 1, 32'h40, B,     0, 32'h0,           1, 1, 32'h40, B,     0, J,     0, L,     1, 1};
    vecs[17] = '{0, 32'h0,    1, 1, 32'h40, B,     1, 32'hFFFFFFFF,    1, 1, 32'h40, B,     0, J,     0, L,     1, 1};
    vecs[18] = '{0, 32'h0,    1, 1, 32'h40, B,     0, 32'h0,           0, 1, 32'h40, B,     0, J,     1, L,     0, 1};
    vecs[19] = '{0, 32'h0,    0, 0, 32'h0,  32'h0, 0, 32'h0,           0, 1, 32'h40, B,     0, J,     0, L,     0, 0};
    vecs[20] = '{0, 32'h0,    0, 0, 32'h0,  32'h0, 1, 32'h55,          0, 1, 32'h40, B,     0, J,     0, L,     0, 0};

    rst_i = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk_i); #1;
      if_req_i = vecs[i].if_req;  if_addr_i = vecs[i].if_addr;
      d_req_i = vecs[i].d_req;    d_we_i = vecs[i].d_we;
      d_addr_i = vecs[i].d_addr;  d_wdata_i = vecs[i].d_wdata;
      mem_ack_i = vecs[i].ack;    mem_rdata_i = vecs[i].rdata;
      @(negedge clk_i);
      check($sformatf("v%0d mem_req", i),  {31'd0, mem_req_o},  {31'd0, vecs[i].e_mem_req});
      check($sformatf("v%0d mem_we", i),   {31'd0, mem_we_o},   {31'd0, vecs[i].e_we});
      check($sformatf("v%0d mem_addr", i), mem_addr_o,          vecs[i].e_addr);
      check($sformatf("v%0d mem_wdata", i), mem_wdata_o,        vecs[i].e_wdata);
      check($sformatf("v%0d if_ready", i), {31'd0, if_ready_o}, {31'd0, vecs[i].e_if_ready});
      check($sformatf("v%0d if_rdata", i), if_rdata_o,          vecs[i].e_if_rdata);
      check($sformatf("v%0d d_ready", i),  {31'd0, d_ready_o},  {31'd0, vecs[i].e_d_ready});
      check($sformatf("v%0d d_rdata", i),  d_rdata_o,           vecs[i].e_d_rdata);
      check($sformatf("v%0d stall", i),    {31'd0, stall_o},    {31'd0, vecs[i].e_stall});
      check($sformatf("v%0d busy", i),     {31'd0, busy_o},     {31'd0, vecs[i].e_busy});
    end

    // Starvation: both requesters held, memory acks immediately.
    exp_addr = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h100, 32'h200};
    exp_cnt  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1};
    ngrant = 0;
    prev_req = 1'b0;
    @(posedge clk_i); #1;
    if_req_i = 1'b1; if_addr_i = 32'h100;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h200; d_wdata_i = 32'h0;
    for (int c = 0; c < 100 && ngrant < 6; c++) begin
      @(negedge clk_i);
      if (mem_req_o && !prev_req) begin
        check($sformatf("grant%0d addr", ngrant), mem_addr_o, exp_addr[ngrant]);
        check($sformatf("grant%0d starve_cnt", ngrant), {28'd0, dut.starve_cnt_r}, {28'd0, exp_cnt[ngrant]});
        ngrant++;
      end
      prev_req = mem_req_o;
      @(posedge clk_i); #1;
      mem_ack_i = mem_req_o;
      mem_rdata_i = 32'hA5A50000 + 32'(c);
    end
    check("starve grant count", 32'(ngrant), 32'd6);
    if_req_i = 1'b0; d_req_i = 1'b0;
    repeat (4) begin
      @(posedge clk_i); #1;
      mem_ack_i = mem_req_o;
    end
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    check("drain busy", {31'd0, busy_o}, 32'd0);

    // Reset in the middle of a load; a late ack must be ignored.
    @(posedge clk_i); #1;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h300;
    seen_busy = 1'b0;
    for (int c = 0; c < 10 && !seen_busy; c++) begin
      @(negedge clk_i);
      if (mem_req_o) seen_busy = 1'b1;
    end
    check("reset test reached BUSY_D", {31'd0, seen_busy}, 32'd1);
    @(posedge clk_i); #1;
    rst_i = 1'b0; d_req_i = 1'b0;
    #1;
    check("rst mem_req", {31'd0, mem_req_o}, 32'd0);
    check("rst mem_addr", mem_addr_o, 32'd0);
    check("rst mem_we", {31'd0, mem_we_o}, 32'd0);
    check("rst mem_wdata", mem_wdata_o, 32'd0);
    check("rst d_rdata", d_rdata_o, 32'd0);
    check("rst if_rdata", if_rdata_o, 32'd0);
    check("rst d_ready", {31'd0, d_ready_o}, 32'd0);
    check("rst busy", {31'd0, busy_o}, 32'd0);
    check("rst stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h99;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      check($sformatf("post-rst c%0d d_ready", c), {31'd0, d_ready_o}, 32'd0);
      check($sformatf("post-rst c%0d mem_req", c), {31'd0, mem_req_o}, 32'd0);
      check($sformatf("post-rst c%0d busy", c),    {31'd0, busy_o},    32'd0);
      check($sformatf("post-rst c%0d d_rdata", c), d_rdata_o,          32'd0);
      @(posedge clk_i); #1;
      mem_ack_i = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
